// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared types, defaults and helpers for the UART transmit FIFO arbiter.
//   st_t        : arbiter state encoding (ST_IDLE, ST_BUSY)
//   N_REQ_DEF   : default number of producers
//   D_WIDTH_DEF : default byte width
//   onehot(idx) : 8-bit one-hot decode of a producer index (N_REQ <= 8)
package uart_arb_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} st_t;
  localparam int N_REQ_DEF = 4;
  localparam int D_WIDTH_DEF = 8;
  function automatic logic [7:0] onehot(input logic [2:0] idx);
    return 8'(1) << idx;
  endfunction
endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// rr_picker: combinational round-robin picker, reusable for any shared resource.
//   req     in  N_REQ  request vector
//   ptr     in  IW     index searched first; search wraps past N_REQ-1 to 0
//   winner  out IW     first requesting index at or after ptr (0 when none)
//   any_req out 1      at least one request is set
module rr_picker #(
  parameter int N_REQ = 4,
  parameter int IW = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [IW-1:0]    winner,
  output logic             any_req
);
  logic [N_REQ-1:0] w_rot;
  // Rotate so that bit 0 is the request at ptr; the lowest set bit wins.
  assign w_rot = N_REQ'({req, req} >> ptr);
  assign any_req = |req;
  always_comb begin
    winner = '0;
    for (int k = N_REQ - 1; k >= 0; k--)
      if (w_rot[k]) winner = IW'((int'(ptr) + k) % N_REQ);
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-locked round-robin sharing of the UART TX FIFO write port.
//   clk          in  1              system clock
//   reset_n      in  1              asynchronous active-low reset
//   req          in  N_REQ          producer i has a byte valid
//   req_data     in  N_REQ*D_WIDTH  byte of producer i at [i*D_WIDTH +: D_WIDTH]
//   req_last     in  N_REQ          byte of producer i ends its packet
//   ack          out N_REQ          one-hot, byte of producer i written this cycle
//   grant        out N_REQ          one-hot current owner, zero when idle
//   busy         out 1              a packet lock is held
//   fifo_full    in  1              FIFO full flag; stalls writes
//   fifo_wr      out 1              FIFO write strobe
//   fifo_wr_data out D_WIDTH        FIFO write data, zero when not writing
//   timeout_tick out 1              one-cycle pulse on forced release (UART_ARB_TIMEOUT_EN only)
// Build option: define UART_ARB_TIMEOUT_EN to release an owner that stays silent for
// TIMEOUT busy cycles; without it the lock is held until the owner's last byte.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int D_WIDTH = D_WIDTH_DEF
`ifdef UART_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 255
`endif
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*D_WIDTH-1:0] req_data,
  input  logic [N_REQ-1:0]         req_last,
  output logic [N_REQ-1:0]         ack,
  output logic [N_REQ-1:0]         grant,
  output logic                     busy,
  input  logic                     fifo_full,
  output logic                     fifo_wr,
  output logic [D_WIDTH-1:0]       fifo_wr_data
`ifdef UART_ARB_TIMEOUT_EN
  ,
  output logic                     timeout_tick
`endif
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  st_t           r_st;
  logic [IW-1:0] r_owner;
  logic [IW-1:0] r_ptr;
  logic [IW-1:0] w_win;
  logic [IW-1:0] w_nxt;
  logic          w_any;
  logic          w_busy;
  logic          w_expire;
  rr_picker #(.N_REQ(N_REQ), .IW(IW)) u_pick (
    .req(req),
    .ptr(r_ptr),
    .winner(w_win),
    .any_req(w_any)
  );
  assign w_busy = (r_st == ST_BUSY);
  assign w_nxt = (r_owner == IW'(N_REQ - 1)) ? '0 : r_owner + 1'b1;
  // Outputs decode the registered state, so reset zeroes them immediately.
  always_comb begin
    busy = w_busy;
    grant = w_busy ? N_REQ'(onehot(3'(r_owner))) : '0;
    fifo_wr = w_busy & req[r_owner] & ~fifo_full;
    ack = fifo_wr ? grant : '0;
    fifo_wr_data = fifo_wr ? req_data[int'(r_owner)*D_WIDTH +: D_WIDTH] : '0;
  end
`ifdef UART_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_cnt;
  logic          r_tick;
  // Only cycles where the owner is silent count; full-FIFO stalls hold the count.
  assign w_expire = w_busy & ~req[r_owner] & (r_cnt == CW'(TIMEOUT - 1));
  assign timeout_tick = r_tick;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_cnt <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= w_expire;
      r_cnt <= (!w_busy || fifo_wr || w_expire) ? '0 : (!req[r_owner]) ? r_cnt + 1'b1 : r_cnt;
    end
`else
  assign w_expire = 1'b0;
`endif
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_st <= ST_IDLE;
      r_owner <= '0;
      r_ptr <= '0;
    end else if (r_st == ST_IDLE) begin
      if (w_any) begin
        r_st <= ST_BUSY;
        r_owner <= w_win;
      end
    end else if ((fifo_wr && req_last[r_owner]) || w_expire) begin
      r_st <= ST_IDLE;
      r_ptr <= w_nxt;
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scoreboard bench for uart_tx_arbiter.
module tb_uart_tx_arbiter;
  localparam int N = 4;
  localparam int W = 8;
  typedef struct packed {
    logic [N-1:0] oh;
    logic [W-1:0] d;
  } exp_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [N-1:0] req = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0] req_last = '0;
  logic [N-1:0] ack;
  logic [N-1:0] grant;
  logic busy;
  logic fifo_full = 1'b0;
  logic fifo_wr;
  logic [W-1:0] fifo_wr_data;
`ifdef UART_ARB_TIMEOUT_EN
  logic timeout_tick;
`endif
  logic [8:0] pq[N][$];
  exp_t sb[$];
  int wr_cyc[$];
  logic [N-1:0] hold = '0;
  logic [N-1:0] pa;
  int total = 0, bad = 0, cyc = 0, nwr = 0, rise0 = -1, base = 0;
  uart_tx_arbiter #(
    .N_REQ(N),
    .D_WIDTH(W)
`ifdef UART_ARB_TIMEOUT_EN
    ,
    .TIMEOUT(4)
`endif
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .req(req),
    .req_data(req_data),
    .req_last(req_last),
    .ack(ack),
    .grant(grant),
    .busy(busy),
    .fifo_full(fifo_full),
    .fifo_wr(fifo_wr),
    .fifo_wr_data(fifo_wr_data)
`ifdef UART_ARB_TIMEOUT_EN
    ,
    .timeout_tick(timeout_tick)
`endif
  );
  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic push(input int p, input logic [W-1:0] d, input logic l);
    pq[p].push_back({l, d});
    sb.push_back({N'(1) << p, d});
  endtask
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  task automatic wait_done(input string tag);
    int n = 0;
    while (sb.size() > 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk({tag, "_drained"}, sb.size(), 0);
  endtask
  task automatic wait_wr(input string tag, input int n);
    int k = 0;
    while (nwr < n && k < 200) begin
      @(posedge clk);
      k++;
    end
    chk({tag, "_wr_seen"}, 32'(nwr >= n), 1);
  endtask
  task automatic do_reset();
    reset_n = 1'b0;
    for (int i = 0; i < N; i++) pq[i].delete();
    sb.delete();
    hold = '0;
    fifo_full = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask
  // Producers: hold byte until acked, advance in the cycle after the ack.
  initial forever begin
    @(negedge clk);
    pa = ack;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (pa[i] && pq[i].size() > 0) void'(pq[i].pop_front());
      if (pq[i].size() > 0 && !hold[i]) begin
        if (i == 0 && !req[0]) rise0 = cyc;
        req[i] = 1'b1;
        req_data[i*W +: W] = pq[i][0][7:0];
        req_last[i] = pq[i][0][8];
      end else begin
        req[i] = 1'b0;
        req_last[i] = 1'b0;
        req_data[i*W +: W] = '0;
      end
    end
  end
  // Monitor: every FIFO write must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (fifo_wr) begin
        nwr++;
        wr_cyc.push_back(cyc);
        if (sb.size() == 0) chk("unexpected_write_sb_size", sb.size(), 1);
        else begin
          e = sb.pop_front();
          chk("wr_data", fifo_wr_data, e.d);
          chk("wr_ack", ack, e.oh);
          chk("wr_grant", grant, e.oh);
        end
      end else begin
        chk("idle_data_zero", fifo_wr_data, 0);
        chk("idle_ack_zero", ack, 0);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
  initial begin
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant, 0);
    chk("rst_fifo_wr", fifo_wr, 0);
    chk("rst_data", fifo_wr_data, 0);
    do_reset();
    // Single producer, two-byte packet.
    base = nwr;
    push(0, 8'h41, 1'b0);
    push(0, 8'h42, 1'b1);
    wait_done("single");
    chk("single_latency", wr_cyc[base] - rise0, 1);
    chk("single_b2b", wr_cyc[base+1] - wr_cyc[base], 1);
    @(negedge clk);
    chk("single_busy_after", busy, 0);
    // Fairness: everyone requests, one-byte packets, two rounds.
    do_reset();
    base = nwr;
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < N; p++) push(p, 8'(8'h10 * p + r), 1'b1);
    wait_done("fair");
    for (int k = 0; k < 7; k++) chk("fair_gap", wr_cyc[base+k+1] - wr_cyc[base+k], 2);
    // Lock: producer 2's three bytes stay contiguous while 1 waits.
    do_reset();
    push(2, 8'h21, 1'b0);
    push(2, 8'h22, 1'b0);
    push(2, 8'h23, 1'b1);
    step();
    push(1, 8'h11, 1'b1);
    wait_done("lock");
    // Full stall mid-packet.
    do_reset();
    base = nwr;
    push(0, 8'h61, 1'b0);
    push(0, 8'h62, 1'b0);
    push(0, 8'h63, 1'b1);
    wait_wr("stall", base + 1);
    #1 fifo_full = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("stall_wr", fifo_wr, 0);
      chk("stall_ack", ack, 0);
      chk("stall_grant", grant, 4'b0001);
    end
    @(posedge clk);
    #1 fifo_full = 1'b0;
    wait_done("stall");
    chk("stall_count", nwr - base, 3);
`ifdef UART_ARB_TIMEOUT_EN
    // Silent owner is released after TIMEOUT idle cycles.
    do_reset();
    base = nwr;
    push(1, 8'hA1, 1'b0);
    pq[1].push_back({1'b1, 8'hA2});
    step();
    push(0, 8'hB0, 1'b1);
    wait_wr("tmo", base + 1);
    hold[1] = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk("tmo_tick", timeout_tick, 32'(k == 5));
      if (k < 5) chk("tmo_busy", busy, 1);
    end
    @(negedge clk);
    chk("tmo_tick_end", timeout_tick, 0);
    wait_done("tmo");
    chk("tmo_count", nwr - base, 2);
    pq[1].delete();
    hold = '0;
`else
    // Owner goes silent mid-packet: lock held, producer 0 waits.
    do_reset();
    base = nwr;
    push(1, 8'hA1, 1'b0);
    push(1, 8'hA2, 1'b1);
    step();
    push(0, 8'hB0, 1'b1);
    wait_wr("drop", base + 1);
    hold[1] = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("drop_wr", fifo_wr, 0);
      chk("drop_grant", grant, 4'b0010);
    end
    hold[1] = 1'b0;
    wait_done("drop");
    chk("drop_count", nwr - base, 3);
`endif
    // Asynchronous reset while producer 3 owns the port.
    do_reset();
    base = nwr;
    push(3, 8'h31, 1'b0);
    push(3, 8'h32, 1'b0);
    push(3, 8'h33, 1'b1);
    wait_wr("rstmid", base + 1);
    #1 fifo_full = 1'b1;
    @(negedge clk);
    chk("rstmid_busy_pre", busy, 1);
    chk("rstmid_grant_pre", grant, 4'b1000);
    #2 reset_n = 1'b0;
    #1 fifo_full = 1'b0;
    #1;
    chk("rstmid_busy", busy, 0);
    chk("rstmid_grant", grant, 0);
    chk("rstmid_wr", fifo_wr, 0);
    chk("rstmid_ack", ack, 0);
    chk("rstmid_data", fifo_wr_data, 0);
    for (int i = 0; i < N; i++) pq[i].delete();
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    push(3, 8'h5A, 1'b1);
    wait_done("rstmid_after");
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
